// File: rtl/sram_usb_reader.sv
// rtl/sram_usb_reader.sv - reads 16-bit SRAM words and streams them low byte first to an FT245 FIFO.
// Optional trailing checksum byte: define SRAM_USB_CHECKSUM_EN.
module sram_usb_reader #(
  parameter int ADDR_W   = 20,
  parameter int RD_WAIT  = 2,
  parameter int WR_PULSE = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [ADDR_W-1:0] BASE_ADRS,
  input  logic [7:0]        XFER_LEN,
  input  logic              ABORT,
  input  logic [15:0]       DX,
  output logic [ADDR_W-1:0] ADX,
  output logic              CEX,
  output logic              CE1,
  output logic              BHE,
  output logic              BLE,
  input  logic              TXE,
  output logic [7:0]        USBX_O,
  output logic              USBX_OE,
  output logic              WR,
  output logic              BUSY,
  output logic              DONE
);

  typedef enum logic [2:0] {IDLE, SR_RD, TX_WAIT, TX_PULSE, TX_HOLD, FINISH} state_t;

  localparam logic [3:0] RD_LAST = 4'(RD_WAIT);
  localparam logic [3:0] WR_LAST = 4'(WR_PULSE - 1);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] ptr;
  logic [8:0]        remaining;
  logic [15:0]       hold;
  logic [3:0]        cnt;
  logic              byte_hi;
  logic              txe_s1, txe_s2;
  logic [7:0]        cur_byte;
  logic              sum_mode;

`ifdef SRAM_USB_CHECKSUM_EN
  logic [7:0] sum;
  assign cur_byte = sum_mode ? sum : (byte_hi ? hold[15:8] : hold[7:0]);
`else
  assign sum_mode = 1'b0;
  assign cur_byte = byte_hi ? hold[15:8] : hold[7:0];
`endif

  assign ADX    = ptr;
  assign USBX_O = USBX_OE ? cur_byte : 8'h00;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      ptr       <= '0;
      remaining <= '0;
      hold      <= '0;
      cnt       <= '0;
      byte_hi   <= 1'b0;
      txe_s1    <= 1'b1;
      txe_s2    <= 1'b1;
`ifdef SRAM_USB_CHECKSUM_EN
      sum       <= '0;
      sum_mode  <= 1'b0;
`endif
    end else begin
      state  <= state_nx;
      txe_s1 <= TXE;
      txe_s2 <= txe_s1;
      cnt    <= (state_nx != state) ? 4'd0 : cnt + 4'd1;
      case (state)
        IDLE: begin
          if (START) begin
            ptr       <= BASE_ADRS;
            remaining <= (XFER_LEN == 8'd0) ? 9'd256 : {1'b0, XFER_LEN};
            byte_hi   <= 1'b0;
`ifdef SRAM_USB_CHECKSUM_EN
            sum       <= '0;
            sum_mode  <= 1'b0;
`endif
          end
        end
        SR_RD: begin
          if (cnt == RD_LAST) begin
            hold    <= DX;
            byte_hi <= 1'b0;
          end
        end
        TX_HOLD: begin
          if (!sum_mode) begin
`ifdef SRAM_USB_CHECKSUM_EN
            sum <= sum + cur_byte;
`endif
            if (!byte_hi) begin
              byte_hi <= 1'b1;
            end else begin
              remaining <= remaining - 9'd1;
              ptr       <= ptr + ADDR_W'(1);
`ifdef SRAM_USB_CHECKSUM_EN
              // last word done: the next TX_WAIT pass carries the sum byte
              if (remaining == 9'd1) begin
                sum_mode <= 1'b1;
                byte_hi  <= 1'b0;
              end
`endif
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    CEX      = 1'b1;
    CE1      = 1'b1;
    BHE      = 1'b1;
    BLE      = 1'b1;
    USBX_OE  = 1'b0;
    WR       = 1'b0;
    BUSY     = 1'b1;
    DONE     = 1'b0;
    case (state)
      IDLE: begin
        BUSY = 1'b0;
        if (START) state_nx = SR_RD;
      end
      SR_RD: begin
        CEX = 1'b0;
        CE1 = 1'b0;
        BHE = 1'b0;
        BLE = 1'b0;
        if (ABORT)                state_nx = FINISH;
        else if (cnt == RD_LAST)  state_nx = TX_WAIT;
      end
      TX_WAIT: begin
        USBX_OE = 1'b1;
        if (ABORT)        state_nx = FINISH;
        else if (!txe_s2) state_nx = TX_PULSE;
      end
      TX_PULSE: begin
        USBX_OE = 1'b1;
        WR      = 1'b1;
        if (cnt == WR_LAST) state_nx = TX_HOLD;
      end
      TX_HOLD: begin
        USBX_OE = 1'b1;
        if (sum_mode)                  state_nx = FINISH;
        else if (!byte_hi)             state_nx = TX_WAIT;
        else if (remaining == 9'd1) begin
`ifdef SRAM_USB_CHECKSUM_EN
          state_nx = TX_WAIT;
`else
          state_nx = FINISH;
`endif
        end else                       state_nx = SR_RD;
      end
      FINISH: begin
        BUSY     = 1'b0;
        DONE     = 1'b1;
        state_nx = IDLE;
      end
      default: begin
        BUSY     = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sram_usb_reader.sv
// tb/tb_sram_usb_reader.sv - self-checking bench for sram_usb_reader against a byte-stream model.
module tb_sram_usb_reader;
  localparam int ADDR_W   = 20;
  localparam int RD_WAIT  = 2;
  localparam int WR_PULSE = 2;
  localparam int WORD_CYC = RD_WAIT + 1 + 2 * (1 + WR_PULSE + 1);

  logic        CLK = 1'b0;
  logic        RST, START, ABORT, TXE;
  logic [19:0] BASE_ADRS;
  logic [7:0]  XFER_LEN;
  logic [15:0] DX;
  logic [19:0] ADX;
  logic        CEX, CE1, BHE, BLE, USBX_OE, WR, BUSY, DONE;
  logic [7:0]  USBX_O;

  sram_usb_reader #(.ADDR_W(ADDR_W), .RD_WAIT(RD_WAIT), .WR_PULSE(WR_PULSE)) dut (
    .CLK(CLK), .RST(RST), .START(START), .BASE_ADRS(BASE_ADRS), .XFER_LEN(XFER_LEN),
    .ABORT(ABORT), .DX(DX), .ADX(ADX), .CEX(CEX), .CE1(CE1), .BHE(BHE), .BLE(BLE),
    .TXE(TXE), .USBX_O(USBX_O), .USBX_OE(USBX_OE), .WR(WR), .BUSY(BUSY), .DONE(DONE)
  );

  always #4 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  // SRAM contents: either addr^key or a two-entry table
  logic [15:0] key = 16'h0;
  logic        use_tab = 1'b0;
  logic [15:0] tab [2];
  always_comb DX = use_tab ? tab[ADX[0]] : (ADX[15:0] ^ key);

  function automatic logic [15:0] word_at(input logic [19:0] a);
    return use_tab ? tab[a[0]] : (a[15:0] ^ key);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0]  got_bytes [$];
  logic [19:0] got_addrs [$];
  logic [7:0]  exp_bytes [$];
  logic [19:0] exp_addrs [$];
  int done_cnt = 0, busy_cnt = 0, wr_rise = 0, cyc = 0, done_cyc = 0;
  logic prev_wr = 1'b0, prev_ce1 = 1'b1, h0 = 1'b0, h1 = 1'b0;

  always @(posedge CLK) begin
    #1;
    cyc++;
    if (!prev_wr && WR) begin
      wr_rise++;
      chk("wr_rise_while_txe_sync_high", 32'(h1), 32'd0);
    end
    if (prev_wr && !WR && USBX_OE) got_bytes.push_back(USBX_O);
    if (prev_ce1 && !CE1) got_addrs.push_back(ADX);
    if (DONE) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (BUSY) busy_cnt++;
    h1 = h0;
    h0 = TXE;
    prev_wr = WR;
    prev_ce1 = CE1;
  end

  task automatic clear_mon();
    got_bytes.delete();
    got_addrs.delete();
    done_cnt = 0;
    busy_cnt = 0;
    wr_rise = 0;
  endtask

  task automatic run_xfer(input logic [19:0] base, input logic [7:0] len, input int stall_after,
                          input int stall_len, input bit do_abort, input bit abort_at_start);
    int n;
    int t;
    int abort_cyc;
    bit stalled;
    logic [7:0]  sum;
    logic [15:0] w;
    logic [19:0] a;
    n = (len == 8'd0) ? 256 : int'(len);
    sum = 8'h0;
    exp_bytes.delete();
    exp_addrs.delete();
    for (int i = 0; i < n; i++) begin
      a = base + 20'(i);
      w = word_at(a);
      exp_addrs.push_back(a);
      exp_bytes.push_back(w[7:0]);
      exp_bytes.push_back(w[15:8]);
      sum = sum + w[7:0] + w[15:8];
    end
`ifdef SRAM_USB_CHECKSUM_EN
    exp_bytes.push_back(sum);
`endif
    if (do_abort) begin
      while (exp_bytes.size() > stall_after) void'(exp_bytes.pop_back());
      while (exp_addrs.size() > stall_after / 2 + 1) void'(exp_addrs.pop_back());
    end
    clear_mon();
    @(negedge CLK);
    BASE_ADRS = base;
    XFER_LEN = len;
    START = 1'b1;
    ABORT = abort_at_start;
    @(negedge CLK);
    START = 1'b0;
    ABORT = 1'b0;
    chk("busy_after_start", 32'(BUSY), 32'd1);
    stalled = 1'b0;
    t = 0;
    abort_cyc = 0;
    for (int c = 0; c < 20000 && done_cnt == 0; c++) begin
      @(negedge CLK);
      ABORT = 1'b0;
      if (done_cnt != 0) break;
      if (stall_after >= 0 && !stalled && got_bytes.size() == stall_after) begin
        TXE = 1'b1;
        stalled = 1'b1;
        t = 0;
      end else if (stalled && TXE) begin
        t++;
        if (do_abort && t == 10) begin
          ABORT = 1'b1;
          abort_cyc = cyc;
        end else if (!do_abort && t == stall_len) begin
          TXE = 1'b0;
        end
      end
    end
    chk("done_seen_in_budget", 32'(done_cnt != 0), 32'd1);
    TXE = 1'b0;
    repeat (4) @(negedge CLK);
    chk("done_pulse_count", 32'(done_cnt), 32'd1);
    chk("busy_after_done", 32'(BUSY), 32'd0);
    chk("ce1_after_done", 32'(CE1), 32'd1);
    chk("usbx_oe_after_done", 32'(USBX_OE), 32'd0);
    chk("byte_count", 32'(got_bytes.size()), 32'(exp_bytes.size()));
    chk("wr_strobe_count", 32'(wr_rise), 32'(exp_bytes.size()));
    for (int i = 0; i < exp_bytes.size() && i < got_bytes.size(); i++)
      chk($sformatf("byte[%0d]", i), 32'(got_bytes[i]), 32'(exp_bytes[i]));
    chk("addr_count", 32'(got_addrs.size()), 32'(exp_addrs.size()));
    for (int i = 0; i < exp_addrs.size() && i < got_addrs.size(); i++)
      chk($sformatf("addr[%0d]", i), 32'(got_addrs[i]), 32'(exp_addrs[i]));
    if (do_abort) chk("abort_to_done_latency_ok", 32'((done_cyc - abort_cyc) inside {[1:2]}), 32'd1);
    if (stall_after < 0 && !do_abort) begin
`ifdef SRAM_USB_CHECKSUM_EN
      chk("busy_cycles", 32'(busy_cnt), 32'(n * WORD_CYC + 2 + WR_PULSE));
`else
      chk("busy_cycles", 32'(busy_cnt), 32'(n * WORD_CYC));
`endif
    end
  endtask

  initial begin
    RST = 1'b1;
    START = 1'b0;
    ABORT = 1'b0;
    TXE = 1'b0;
    BASE_ADRS = '0;
    XFER_LEN = '0;
    tab[0] = 16'h0102;
    tab[1] = 16'h0304;
    repeat (3) @(negedge CLK);
    chk("rst_adx", 32'(ADX), 32'd0);
    chk("rst_cex", 32'(CEX), 32'd1);
    chk("rst_ce1", 32'(CE1), 32'd1);
    chk("rst_bhe", 32'(BHE), 32'd1);
    chk("rst_ble", 32'(BLE), 32'd1);
    chk("rst_usbx_o", 32'(USBX_O), 32'd0);
    chk("rst_usbx_oe", 32'(USBX_OE), 32'd0);
    chk("rst_wr", 32'(WR), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    run_xfer(20'h00010, 8'd2, -1, 0, 1'b0, 1'b0);
    run_xfer(20'hFFFFF, 8'd0, -1, 0, 1'b0, 1'b0);

    key = 16'($urandom);
    run_xfer(20'($urandom), 8'd4, 3, 40, 1'b0, 1'b0);
    key = 16'($urandom);
    run_xfer(20'($urandom), 8'd8, 4, 0, 1'b1, 1'b0);
    run_xfer(20'($urandom), 8'd3, -1, 0, 1'b0, 1'b1);

    // reset in the middle of a write strobe
    clear_mon();
    @(negedge CLK);
    BASE_ADRS = 20'($urandom);
    XFER_LEN = 8'd4;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    for (int c = 0; c < 200 && !WR; c++) @(negedge CLK);
    chk("wr_reached_before_reset", 32'(WR), 32'd1);
    RST = 1'b1;
    @(negedge CLK);
    chk("mid_rst_wr", 32'(WR), 32'd0);
    chk("mid_rst_usbx_oe", 32'(USBX_OE), 32'd0);
    chk("mid_rst_ce1", 32'(CE1), 32'd1);
    chk("mid_rst_busy", 32'(BUSY), 32'd0);
    chk("mid_rst_adx", 32'(ADX), 32'd0);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    run_xfer(20'($urandom), 8'd2, -1, 0, 1'b0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      key = 16'($urandom);
      run_xfer(20'($urandom), 8'($urandom_range(1, 6)), -1, 0, 1'b0, 1'b0);
    end

`ifdef SRAM_USB_CHECKSUM_EN
    use_tab = 1'b1;
    run_xfer(20'h00000, 8'd2, -1, 0, 1'b0, 1'b0);
    chk("csum_len", 32'(got_bytes.size()), 32'd5);
    if (got_bytes.size() == 5) begin
      chk("csum_b0", 32'(got_bytes[0]), 32'h02);
      chk("csum_b1", 32'(got_bytes[1]), 32'h01);
      chk("csum_b2", 32'(got_bytes[2]), 32'h04);
      chk("csum_b3", 32'(got_bytes[3]), 32'h03);
      chk("csum_b4", 32'(got_bytes[4]), 32'h0A);
    end
    use_tab = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sram_usb_reader.md
Name: sram_usb_reader

Overview:
- Readout side of the waveform memory. Once capture has stopped, it reads a block of 16-bit samples from the external async SRAM.
- Each word is serialised low byte first onto the FT245-style USB FIFO write port (USBX/WR/TXE), with TXE flow control.
- Sits between the SRAM pins and the USB byte bus. It is started by the command decoder for the "5: data transfer" command, with length taken from the "8: length set" register.

Parameters:
- ADDR_W, 20, SRAM address width.
- RD_WAIT, 2, number of CLK cycles OE/CE are held low before DX is sampled (range 1..15).
- WR_PULSE, 2, number of CLK cycles WR is held high per byte (range 1..15).

Ports:
- CLK  in  1  system clock, 125 MHz.
- RST  in  1  synchronous reset, active high.
- START  in  1  one-cycle pulse; begins a transfer; ignored while BUSY=1.
- BASE_ADRS  in  ADDR_W  first SRAM word address; latched on START.
- XFER_LEN  in  8  word count; latched on START; 0 means 256.
- ABORT  in  1  synchronous cancel of a transfer in progress.
- DX  in  16  SRAM data bus, input direction only (this block never drives it).
- ADX  out  ADDR_W  SRAM address.
- CEX  out  1  SRAM OE, active low.
- CE1  out  1  SRAM CE, active low.
- BHE  out  1  SRAM upper byte enable, active low.
- BLE  out  1  SRAM lower byte enable, active low.
- TXE  in  1  FT245 transmit-FIFO full flag, active high (0 = may write); asynchronous.
- USBX_O  out  8  byte to USB bus.
- USBX_OE  out  1  tri-state enable for USBX at top level.
- WR  out  1  FT245 write strobe; the byte is taken on the falling edge of WR.
- BUSY  out  1  high from the cycle after START until DONE.
- DONE  out  1  one-cycle pulse when the transfer completes or is aborted.

Behaviour:
- Reset values: ADX=0, CEX=1, CE1=1, BHE=1, BLE=1, USBX_O=0, USBX_OE=0, WR=0, BUSY=0, DONE=0, state=IDLE.
- RST mid-transfer forces the reset values on the next edge; a partially sent word is lost.
- TXE passes through a 2-flop synchroniser before use; its latency to the FSM is 2 cycles.
- State machine:
  - IDLE: on START, latch the address into the pointer and load the remaining count (0 loads 256); set BUSY=1; go to SR_RD.
  - SR_RD: drive ADX=pointer; assert CE1, CEX, BHE, BLE low; count RD_WAIT cycles.
  - Sample DX into a 16-bit hold register in the last SR_RD cycle; deassert CEX and CE1 the next cycle; go to TX_WAIT with byte select = low.
  - TX_WAIT: with USBX_OE=1 and USBX_O = selected byte, wait until synchronised TXE=0.
  - TX_PULSE: WR=1 for WR_PULSE cycles, then WR=0 and go to TX_HOLD.
  - TX_HOLD: 1 cycle with data still held (hold time after the falling WR edge).
    - If the low byte was just sent, select the high byte and go to TX_WAIT.
    - Otherwise decrement the count and increment the pointer (wraps 2^ADDR_W-1 to 0).
    - If the count reaches 0, go to FINISH; else go to SR_RD.
  - FINISH: USBX_OE=0, BUSY=0, DONE=1 for one cycle; go to IDLE.
- Throughput: with TXE held 0, one word takes RD_WAIT + 1 + 2*(1 + WR_PULSE + 1) cycles.
  - Note: TX_WAIT consumes at least 1 cycle.
- TXE rising at any time: only blocks entry to TX_PULSE. A WR pulse already in progress completes.
- ABORT: honoured in SR_RD and TX_WAIT only, never during TX_PULSE/TX_HOLD.
  - Releases the SRAM and USB pins and goes to FINISH.
  - DONE still pulses.
- START and ABORT asserted in the same cycle in IDLE: the transfer starts (ABORT has no effect in IDLE).
- USBX_OE is 0 whenever WR=0 and the FSM is in IDLE or FINISH, so the command-read path can use the bus.

Optional Feature:
- Macro: SRAM_USB_CHECKSUM_EN.
- When defined:
  - An 8-bit modulo-256 sum of every byte sent is kept; it is cleared on START.
  - After the last data byte the FSM passes through TX_WAIT/TX_PULSE/TX_HOLD once more, sending the sum byte, then goes to FINISH.
  - Aborted transfers send no checksum.
- When undefined: no extra byte; the accumulator logic is absent.

Test Plan:
- SRAM model with word[a]=a[15:0], BASE_ADRS=0x00010, XFER_LEN=2, TXE=0:
  - USB bytes in order are 0x10,0x00,0x11,0x00.
  - Exactly 4 WR falling edges; DONE pulses once; BUSY is 0 after.
- XFER_LEN=0, BASE_ADRS=0xFFFFF: 512 bytes are sent; the address sequence is 0xFFFFF, 0x00000..0x000FE; wrap verified.
- TXE forced to 1 after the 3rd byte for 40 cycles, XFER_LEN=4:
  - No WR rise while synchronised TXE=1.
  - Transfer resumes with the 4th byte; no byte is lost or duplicated.
- ABORT pulsed while waiting on TXE=1 during word 3 of 8:
  - DONE pulses within 2 cycles; only 4 bytes were strobed.
  - CE1=1, USBX_OE=0 afterwards.
- RST asserted mid-TX_PULSE: the next cycle shows WR=0, USBX_OE=0, CE1=1, BUSY=0; a new START then runs normally.
- SRAM_USB_CHECKSUM_EN defined, words 0x0102 and 0x0304: the bytes sent are 0x02,0x01,0x04,0x03,0x0A.
